jk_cmd_seq: RTL

- Upstream driver stage for the jkff flip-flop.
- Accepts high-level commands (hold/reset/set/toggle plus a repeat count) over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered j/k into the flip-flop, one command per cycle-run, and optionally runs a shadow model of the flip-flop that checks the returned q.

---
 rtl/jk_pkg.sv | 32 +++
 rtl/jk_cmd_fifo.sv | 61 ++++++
 rtl/jk_cmd_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types for the jkff command sequencer: op encoding, FSM states and
// the reference next-state function of a JK flip-flop.
package jk_pkg;

  // Op encoding maps straight onto the flip-flop inputs: j = op[1], k = op[0].
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } jk_state_e;

  localparam int OP_W = 2;

  // Value a JK flip-flop holds after one clock with inputs {j,k} = op.
  function automatic logic jk_next(input logic q, input jk_op_e op);
    logic nq;
    case (op)
      SET:     nq = 1'b1;
      RST:     nq = 1'b0;
      TGL:     nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small show-ahead command FIFO. The head entry is visible combinationally
// whenever the FIFO is non-empty. Pointers carry one extra wrap bit so that
// full and empty fall out of pointer comparison alone.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok;
  logic         pop_ok;

  // Same index with different wrap bits means the writer is a full lap ahead.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push is refused when full even if a pop frees a slot this same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_o = mem[rd_ptr_q[AW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// Command sequencer driving a JK flip-flop. Commands (op + repeat count) are
// buffered in a FIFO and each is applied to registered j/k for rpt+1 cycles,
// back to back with no bubble. Defining JKSEQ_CHECK_EN adds a shadow model
// of the flip-flop that flags (stickily) any mismatch on the returned q.
module jk_cmd_seq
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RPT_W-1:0] cmd_rpt,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             idle,
  output logic             cmd_done,
  output logic             q_err
);

  localparam int CW = OP_W + RPT_W;

  jk_state_e        state_q, state_d;
  jk_op_e           jk_q, jk_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             pop;
  logic             done_w;

  logic [CW-1:0]    head;
  logic             full;
  logic             empty;
  jk_op_e           head_op;
  logic [RPT_W-1:0] head_rpt;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .din_i   ({cmd_op, cmd_rpt}),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_op  = jk_op_e'(head[CW-1 -: OP_W]);
  assign head_rpt = head[RPT_W-1:0];

  assign cmd_ready = !full;
  assign idle      = empty && (state_q == IDLE);
  assign cmd_done  = done_w;
  assign j         = jk_q[1];
  assign k         = jk_q[0];

  // Next-state logic: load from the FIFO head, count down, chain commands.
  always_comb begin
    state_d = state_q;
    jk_d    = jk_q;
    rpt_d   = rpt_q;
    pop     = 1'b0;
    done_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          jk_d    = head_op;
          rpt_d   = head_rpt;
          state_d = DRIVE;
        end else begin
          jk_d = HOLD;
        end
      end
      DRIVE: begin
        if (rpt_q != '0) begin
          rpt_d = rpt_q - RPT_W'(1);
        end else begin
          // Last cycle of this command is on j/k right now.
          done_w = 1'b1;
          if (!empty) begin
            pop   = 1'b1;
            jk_d  = head_op;
            rpt_d = head_rpt;
          end else begin
            jk_d    = HOLD;
            state_d = IDLE;
          end
        end
      end
      default: begin
        jk_d    = HOLD;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      jk_q    <= HOLD;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      jk_q    <= jk_d;
      rpt_q   <= rpt_d;
    end
  end

`ifdef JKSEQ_CHECK_EN
  logic exp_q, exp_d;
  logic known_q, known_d;
  logic q_err_q, q_err_d;

  // Shadow model tracks the flip-flop from the same registered j/k it sees;
  // the comparison is written so an unknown q_in lands in the mismatch arm.
  always_comb begin
    exp_d   = jk_next(exp_q, jk_q);
    known_d = known_q || (jk_q == SET) || (jk_q == RST);
    q_err_d = q_err_q;
    if (known_q) begin
      if (q_in == exp_q) q_err_d = q_err_q;
      else               q_err_d = 1'b1;
    end
  end

  // Model and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q   <= 1'b0;
      known_q <= 1'b0;
      q_err_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      known_q <= known_d;
      q_err_q <= q_err_d;
    end
  end

  assign q_err = q_err_q;
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign q_err       = 1'b0;
`endif

endmodule
